// File: rtl/ram_port_arbiter_pkg.sv
// Shared helpers for ram_port_arbiter: client-index width and legal client-count check.
package ram_port_arbiter_pkg;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit n_is_valid(input int unsigned n);
        return (n == 2) || (n == 4) || (n == 8);
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// and advances the pointer past the winner.
module rr_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned ID_WIDTH = id_width(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req,
    output logic [N-1:0]        gnt,
    output logic [ID_WIDTH-1:0] gnt_id,
    output logic                gnt_valid
);

    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] idx;

    // Scan from the farthest offset down so the nearest request to ptr wins last.
    always_comb begin
        gnt_id    = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int unsigned k = N; k > 0; k--) begin
            idx = ptr + ID_WIDTH'(k - 1);
            if (req[idx]) begin
                gnt_id    = idx;
                gnt_valid = 1'b1;
            end
        end
        if (reset) begin
            gnt_valid = 1'b0;
        end
        gnt = gnt_valid ? (N'(1) << gnt_id) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (gnt_valid) begin
            ptr <= gnt_id + ID_WIDTH'(1);
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one simple dual-port RAM among N clients with independent
// round-robin arbitration of the write and read ports.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned N          = 4,
    localparam int unsigned ID_WIDTH  = id_width(N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N-1:0]            wr_req,
    input  logic [N*ADDR_WIDTH-1:0] wr_addr,
    input  logic [N*DATA_WIDTH-1:0] wr_data,
    output logic [N-1:0]            wr_ack,
    input  logic [N-1:0]            rd_req,
    input  logic [N*ADDR_WIDTH-1:0] rd_addr,
    output logic [N-1:0]            rd_ack,
    output logic                    rd_valid,
    output logic [ID_WIDTH-1:0]     rd_id,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_w_addr,
    output logic [DATA_WIDTH-1:0]   ram_d,
    output logic [ADDR_WIDTH-1:0]   ram_r_addr,
    input  logic [DATA_WIDTH-1:0]   ram_q
);

    if (!n_is_valid(N)) begin : g_bad_n
        $error("ram_port_arbiter: N must be 2, 4 or 8");
    end

    logic [ID_WIDTH-1:0] wr_gnt_id;
    logic [ID_WIDTH-1:0] rd_gnt_id;
    logic                wr_gnt_valid;
    logic                rd_gnt_valid;

    rr_arbiter #(.N(N)) u_wr_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (wr_req),
        .gnt       (wr_ack),
        .gnt_id    (wr_gnt_id),
        .gnt_valid (wr_gnt_valid)
    );

    rr_arbiter #(.N(N)) u_rd_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (rd_req),
        .gnt       (rd_ack),
        .gnt_id    (rd_gnt_id),
        .gnt_valid (rd_gnt_valid)
    );

    // With no grant the muxes still select a real client slice, so nothing floats to X.
    always_comb begin
        ram_w_addr = wr_addr[ADDR_WIDTH-1:0];
        ram_d      = wr_data[DATA_WIDTH-1:0];
        ram_r_addr = rd_addr[ADDR_WIDTH-1:0];
        for (int unsigned i = 0; i < N; i++) begin
            if (wr_gnt_id == ID_WIDTH'(i)) begin
                ram_w_addr = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                ram_d      = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rd_gnt_id == ID_WIDTH'(i)) begin
                ram_r_addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign ram_we  = wr_gnt_valid;
    assign rd_data = ram_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_id    <= '0;
        end else begin
            rd_valid <= rd_gnt_valid;
            if (rd_gnt_valid) begin
                rd_id <= rd_gnt_id;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with an abstract per-cycle model and a behavioural RAM.
module tb_ram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int N  = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      wr_req = '0;
    logic [N*AW-1:0]   wr_addr = '0;
    logic [N*DW-1:0]   wr_data = '0;
    logic [N-1:0]      wr_ack;
    logic [N-1:0]      rd_req = '0;
    logic [N*AW-1:0]   rd_addr = '0;
    logic [N-1:0]      rd_ack;
    logic              rd_valid;
    logic [IW-1:0]     rd_id;
    logic [DW-1:0]     rd_data;
    logic              ram_we;
    logic [AW-1:0]     ram_w_addr;
    logic [DW-1:0]     ram_d;
    logic [AW-1:0]     ram_r_addr;
    logic [DW-1:0]     ram_q;

    int compared = 0;
    int mismatched = 0;
    int edges = 0;

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_valid   (rd_valid),
        .rd_id      (rd_id),
        .rd_data    (rd_data),
        .ram_we     (ram_we),
        .ram_w_addr (ram_w_addr),
        .ram_d      (ram_d),
        .ram_r_addr (ram_r_addr),
        .ram_q      (ram_q)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: write-first on a same-address collision.
    logic [DW-1:0] tb_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        ram_q <= (ram_we && ram_w_addr == ram_r_addr) ? ram_d : tb_mem[ram_r_addr];
        if (ram_we) tb_mem[ram_w_addr] <= ram_d;
        edges <= edges + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- abstract model ----------------
    int m_wr_ptr = 0;
    int m_rd_ptr = 0;
    int m_mem[int];
    bit m_pend_v = 0;
    int m_pend_id = 0;
    bit m_pend_known = 0;
    int m_pend_data = 0;

    function automatic int pick(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (edges > 0) begin
            int wg, rg, wa, wd, ra;
            wg = reset ? -1 : pick(m_wr_ptr, wr_req);
            rg = reset ? -1 : pick(m_rd_ptr, rd_req);
            chk("wr_ack", 32'(wr_ack), (wg < 0) ? 0 : (1 << wg));
            chk("rd_ack", 32'(rd_ack), (rg < 0) ? 0 : (1 << rg));
            chk("ram_we", 32'(ram_we), (wg < 0) ? 0 : 1);
            if (wg >= 0) begin
                wa = int'(wr_addr[wg*AW +: AW]);
                wd = int'(wr_data[wg*DW +: DW]);
                chk("ram_w_addr", 32'(ram_w_addr), wa);
                chk("ram_d", 32'(ram_d), wd);
            end
            if (rg >= 0) begin
                ra = int'(rd_addr[rg*AW +: AW]);
                chk("ram_r_addr", 32'(ram_r_addr), ra);
            end
            chk("rd_valid", 32'(rd_valid), m_pend_v);
            if (m_pend_v) begin
                chk("rd_id", 32'(rd_id), m_pend_id);
                if (m_pend_known) chk("rd_data", 32'(rd_data), m_pend_data);
            end
            if (reset) begin
                m_wr_ptr = 0;
                m_rd_ptr = 0;
                m_pend_v = 0;
                m_pend_id = 0;
            end else begin
                if (wg >= 0) begin
                    m_mem[wa] = wd;
                    m_wr_ptr = (wg + 1) % N;
                end
                m_pend_v = (rg >= 0);
                if (rg >= 0) begin
                    m_pend_id = rg;
                    m_pend_known = m_mem.exists(ra);
                    m_pend_data = m_pend_known ? m_mem[ra] : 0;
                    m_rd_ptr = (rg + 1) % N;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int c, input int a, input int d);
        wr_addr[c*AW +: AW] = AW'(a);
        wr_data[c*DW +: DW] = DW'(d);
    endtask

    task automatic set_rd(input int c, input int a);
        rd_addr[c*AW +: AW] = AW'(a);
    endtask

    logic [N-1:0] rot_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [N-1:0] alt_exp [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};

    initial begin
        reset = 1'b1;
        repeat (3) next_cycle();
        reset = 1'b0;

        // Idle after reset release
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            @(negedge clk);
            chk("idle_acks", 32'({wr_ack, rd_ack}), 0);
            chk("idle_we_valid", 32'({ram_we, rd_valid}), 0);
        end
        chk("reset_rd_id", 32'(rd_id), 0);

        // Client 2 writes 0x05 <= 0xA5, then reads it back
        next_cycle();
        set_wr(2, 'h05, 'hA5);
        wr_req = 4'b0100;
        @(negedge clk);
        chk("wr2_ack", 32'(wr_ack), 4'b0100);
        next_cycle();
        wr_req = '0;
        set_rd(2, 'h05);
        rd_req = 4'b0100;
        @(negedge clk);
        chk("rd2_ack", 32'(rd_ack), 4'b0100);
        chk("rd2_valid_early", 32'(rd_valid), 0);
        next_cycle();
        rd_req = '0;
        @(negedge clk);
        chk("rd2_valid", 32'(rd_valid), 1);
        chk("rd2_id", 32'(rd_id), 2);
        chk("rd2_data", 32'(rd_data), 'hA5);

        // Grant client 3 once to bring rd_ptr back to 0
        next_cycle();
        for (int c = 0; c < N; c++) set_rd(c, 'h05);
        rd_req = 4'b1000;
        next_cycle();
        rd_req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rot_ack", 32'(rd_ack), 32'(rot_exp[k]));
            if (k > 0) chk("rot_id", 32'(rd_id), (k - 1) % N);
            next_cycle();
        end
        rd_req = '0;

        // Same-cycle write (client 0) and read (client 1) of 0x10
        set_wr(0, 'h10, 'h3C);
        set_rd(1, 'h10);
        wr_req = 4'b0001;
        rd_req = 4'b0010;
        @(negedge clk);
        chk("same_wr_ack", 32'(wr_ack), 4'b0001);
        chk("same_rd_ack", 32'(rd_ack), 4'b0010);
        next_cycle();
        wr_req = '0;
        rd_req = '0;
        @(negedge clk);
        chk("same_rd_data", 32'(rd_data), 'h3C);
        chk("same_rd_id", 32'(rd_id), 1);

        // rd_ptr is now 2; clients 1 and 3 alternate, starting with 3
        next_cycle();
        rd_req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("alt_ack", 32'(rd_ack), 32'(alt_exp[k]));
            next_cycle();
        end

        // Read ack, then reset in the following cycle
        rd_req = 4'b0100;
        @(negedge clk);
        chk("pre_rst_ack", 32'(rd_ack), 4'b0100);
        next_cycle();
        reset = 1'b1;
        rd_req = 4'b0110;
        set_wr(2, 'h20, 'h77);
        set_wr(3, 'h21, 'h88);
        wr_req = 4'b1100;
        @(negedge clk);
        chk("rst_rd_valid", 32'(rd_valid), 1);
        chk("rst_acks", 32'({wr_ack, rd_ack}), 0);
        chk("rst_we", 32'(ram_we), 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(rd_valid), 0);
        chk("post_rst_rd_ack", 32'(rd_ack), 4'b0010);
        chk("post_rst_wr_ack", 32'(wr_ack), 4'b0100);
        next_cycle();
        rd_req = '0;
        wr_req = '0;
        @(negedge clk);
        chk("post_rst_rd_id", 32'(rd_id), 1);
        repeat (3) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
